// File: rtl/uart_word_sender.sv
// Buffers 32-bit words in a FIFO and sends each as four UART frames, MSB byte first.
// Define UART_WORD_SENDER_PARITY_EN to add an even-parity bit to every frame.
module uart_word_sender #(
    parameter int CLK_PER_BIT = 2604,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          CLK,
    input  logic                          INITIALIZE,
    input  logic [31:0]                   word_in,
    input  logic                          word_valid,
    output logic                          word_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          UART_TX
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(CLK_PER_BIT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_WORD_SENDER_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]    bit_idx, bit_n;
    logic [1:0]    byte_idx, byte_n;
    logic [31:0]   shreg, sh_n;
    logic          tx_n;
    logic          tick;
    logic          push, pop;
    logic [7:0]    cur_byte;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_n;

    assign word_ready = (fifo_count != CW'(FIFO_DEPTH));
    assign push       = word_valid && word_ready;
    assign busy       = (state != IDLE) || (fifo_count != '0);
    assign tick       = (timer == TW'(CLK_PER_BIT - 1));
    assign cur_byte   = shreg[31:24];

    always_comb begin
        count_n = fifo_count;
        if (push && !pop)
            count_n = fifo_count + CW'(1);
        else if (!push && pop)
            count_n = fifo_count - CW'(1);
    end

    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= word_in;
    end

    always_ff @(posedge CLK or posedge INITIALIZE) begin
        if (INITIALIZE) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= count_n;
        end
    end

    always_ff @(posedge CLK or posedge INITIALIZE) begin
        if (INITIALIZE) begin
            state    <= IDLE;
            timer    <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            shreg    <= '0;
            UART_TX  <= 1'b1;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            bit_idx  <= bit_n;
            byte_idx <= byte_n;
            shreg    <= sh_n;
            UART_TX  <= tx_n;
        end
    end

    always_comb begin
        state_n = state;
        timer_n = timer;
        bit_n   = bit_idx;
        byte_n  = byte_idx;
        sh_n    = shreg;
        tx_n    = UART_TX;
        pop     = 1'b0;
        // Timer free-runs in every non-idle state so frames never drift
        if (state != IDLE)
            timer_n = tick ? '0 : timer + TW'(1);
        unique case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop     = 1'b1;
                    sh_n    = mem[rd_ptr];
                    byte_n  = '0;
                    tx_n    = 1'b0;
                    state_n = START;
                end
            end
            START: begin
                if (tick) begin
                    state_n = DATA;
                    bit_n   = '0;
                    tx_n    = cur_byte[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx == 3'd7) begin
`ifdef UART_WORD_SENDER_PARITY_EN
                        state_n = PARITY;
                        tx_n    = ^cur_byte;
`else
                        state_n = STOP;
                        tx_n    = 1'b1;
`endif
                    end else begin
                        bit_n = bit_idx + 3'd1;
                        tx_n  = cur_byte[bit_idx + 3'd1];
                    end
                end
            end
`ifdef UART_WORD_SENDER_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (byte_idx != 2'd3) begin
                        byte_n  = byte_idx + 2'd1;
                        sh_n    = {shreg[23:0], 8'h00};
                        tx_n    = 1'b0;
                        state_n = START;
                    end else if (fifo_count != '0) begin
                        pop     = 1'b1;
                        sh_n    = mem[rd_ptr];
                        byte_n  = '0;
                        tx_n    = 1'b0;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
